// File: rtl/hs_unit_skid_buffer.sv
// hs_unit_skid_buffer: two-entry valid/ready register slice with fully registered outputs
module hs_unit_skid_buffer #(
    parameter type DATA_TYPE = logic
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_valid,
    output logic       s_ready,
    input  DATA_TYPE   s_data,
    output logic       m_valid,
    input  logic       m_ready,
    output DATA_TYPE   m_data,
    output logic [1:0] occupancy
);
    typedef enum logic [1:0] {EMPTY = 2'd0, BUSY = 2'd1, FULL = 2'd2} state_t;
    state_t   state_q, state_d;
    DATA_TYPE main_q, main_d, skid_q, skid_d;
    logic     s_ready_q, s_ready_d, m_valid_q, m_valid_d;
    logic     xfer_in, xfer_out;
    assign xfer_in  = s_valid & s_ready_q;
    assign xfer_out = m_valid_q & m_ready;
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: if (xfer_in) begin
                main_d  = s_data;
                state_d = BUSY;
            end
            BUSY: begin
                main_d  = xfer_in & xfer_out ? s_data : main_q;
                skid_d  = xfer_in & !xfer_out ? s_data : skid_q;
                state_d = xfer_in & !xfer_out ? FULL : (!xfer_in & xfer_out ? EMPTY : BUSY);
            end
            FULL: if (xfer_out) begin
                main_d  = skid_q;
                state_d = BUSY;
            end
            default: state_d = EMPTY;
        endcase
        s_ready_d = state_d != FULL;
        m_valid_d = state_d != EMPTY;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= EMPTY;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            s_ready_q <= s_ready_d;
            m_valid_q <= m_valid_d;
        end
    end
    always_ff @(posedge clk) begin
        main_q <= main_d;
        skid_q <= skid_d;
    end
    assign s_ready   = s_ready_q;
    assign m_valid   = m_valid_q;
    assign m_data    = main_q;
    assign occupancy = state_q == FULL ? 2'd2 : (state_q == BUSY ? 2'd1 : 2'd0);
endmodule

// File: tb/tb_hs_unit_skid_buffer.sv
// tb_hs_unit_skid_buffer: directed and queue-model checks of the skid buffer
module tb_hs_unit_skid_buffer;
    logic       clk = 1'b0;
    logic       rst, s_valid, s_ready, m_valid, m_ready;
    logic [7:0] s_data, m_data;
    logic [1:0] occupancy;
    int         compared = 0;
    int         failed = 0;
    logic [7:0] q[$];
    logic       sv, mr, in_m, out_m;

    hs_unit_skid_buffer #(.DATA_TYPE(logic [7:0])) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic mv, input logic sr, input logic [1:0] occ);
        chk({tag, ".m_valid"}, 32'(m_valid), 32'(mv));
        chk({tag, ".s_ready"}, 32'(s_ready), 32'(sr));
        chk({tag, ".occupancy"}, 32'(occupancy), 32'(occ));
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b1; s_data = 8'h55; m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_state("reset", 1'b0, 1'b0, 2'd0);
        end
        rst = 1'b0;
        tick();
        chk_state("reset_release", 1'b0, 1'b1, 2'd0);
        s_valid = 1'b0;
        tick();
        chk_state("reset_idle", 1'b0, 1'b1, 2'd0);

        m_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            s_valid = 1'b1; s_data = 8'(i);
            tick();
            chk_state("stream", 1'b1, 1'b1, 2'd1);
            chk("stream.m_data", 32'(m_data), 32'(i));
        end
        s_valid = 1'b0;
        tick();
        chk_state("stream_end", 1'b0, 1'b1, 2'd0);

        m_ready = 1'b0; s_valid = 1'b1; s_data = 8'hA1;
        tick();
        chk_state("fill1", 1'b1, 1'b1, 2'd1);
        chk("fill1.m_data", 32'(m_data), 32'hA1);
        s_data = 8'hA2;
        tick();
        chk_state("fill2", 1'b1, 1'b0, 2'd2);
        chk("fill2.m_data", 32'(m_data), 32'hA1);
        s_data = 8'hA3;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk_state("stall", 1'b1, 1'b0, 2'd2);
            chk("stall.m_data", 32'(m_data), 32'hA1);
        end

        m_ready = 1'b1;
        tick();
        chk_state("drain1", 1'b1, 1'b1, 2'd1);
        chk("drain1.m_data", 32'(m_data), 32'hA2);
        tick();
        chk_state("drain2", 1'b1, 1'b1, 2'd1);
        chk("drain2.m_data", 32'(m_data), 32'hA3);
        s_valid = 1'b0;
        tick();
        chk_state("drain3", 1'b0, 1'b1, 2'd0);

        q.delete();
        for (int i = 0; i < 10000; i++) begin
            sv = 1'($urandom_range(1)); mr = 1'($urandom_range(1));
            s_valid = sv; m_ready = mr; s_data = 8'($urandom);
            chk("rand.m_valid", 32'(m_valid), 32'(q.size() > 0));
            chk("rand.s_ready", 32'(s_ready), 32'(q.size() < 2));
            chk("rand.occupancy", 32'(occupancy), 32'(q.size()));
            if (q.size() > 0) chk("rand.m_data", 32'(m_data), 32'(q[0]));
            in_m = sv && q.size() < 2;
            out_m = mr && q.size() > 0;
            tick();
            if (out_m) void'(q.pop_front());
            if (in_m) q.push_back(s_data);
        end
        s_valid = 1'b0; m_ready = 1'b1;
        tick();
        tick();
        chk_state("rand_drain", 1'b0, 1'b1, 2'd0);

        m_ready = 1'b0; s_valid = 1'b1; s_data = 8'hB1;
        tick();
        s_data = 8'hB2;
        tick();
        chk_state("midrst_full", 1'b1, 1'b0, 2'd2);
        s_valid = 1'b0; rst = 1'b1;
        tick();
        chk_state("midrst", 1'b0, 1'b0, 2'd0);
        rst = 1'b0;
        tick();
        chk_state("midrst_release", 1'b0, 1'b1, 2'd0);
        m_ready = 1'b1; s_valid = 1'b1; s_data = 8'hC0;
        tick();
        chk_state("after_rst", 1'b1, 1'b1, 2'd1);
        chk("after_rst.m_data", 32'(m_data), 32'hC0);
        s_valid = 1'b0;
        tick();
        chk_state("after_rst_empty", 1'b0, 1'b1, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end
endmodule
